seq_ctrl: RTL and testbench

Instruction sequencer and register-file owner for the Nexys3 calculator datapath. It buffers debounced instruction words (`inst_wd` qualified by `inst_vld`) in a 4-entry FIFO and executes them one at a time against a 4×8-bit register file. Supported instructions are PUSH, ADD, MULT and SEND. For SEND it drives a valid/ready byte handshake into the UART transmitter. It sits between the switch/button front end and the UART TX and LED outputs of `nexys3`.

---
 rtl/seq_ctrl_if.sv | 20 ++
 rtl/seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_ctrl_if.sv
// seq_ctrl_if: instruction strobe channel and UART byte handshake.
// master drives instructions and tx_rdy; slave is the sequencer.
interface seq_ctrl_if;
   logic [7:0] inst_wd;
   logic       inst_vld;
   logic       inst_rdy;
   logic [7:0] tx_data;
   logic       tx_vld;
   logic       tx_rdy;

   modport master (
      output inst_wd, inst_vld, tx_rdy,
      input  inst_rdy, tx_data, tx_vld
   );

   modport slave (
      input  inst_wd, inst_vld, tx_rdy,
      output inst_rdy, tx_data, tx_vld
   );
endinterface

// File: rtl/seq_ctrl.sv
// seq_ctrl: instruction FIFO + sequencer owning a 4x8 register file.
// Define SEQ_CTRL_MULT_EN to build the MULT datapath (else MULT is a NOP).
module seq_ctrl #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   seq_ctrl_if.slave  bus,
   output logic [7:0] led,
   output logic       busy,
   output logic       drop
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, EXEC, SEND_WAIT} state_t;

   state_t      state;
   logic [7:0]  fifo [FIFO_DEPTH];
   logic [AW:0] wptr;
   logic [AW:0] rptr;
   logic        full;
   logic        empty;
   logic        push;
   logic        pop;
   logic [7:0]  cur_inst;
   logic [7:0]  rf [4];
   logic [1:0]  op;
   logic [1:0]  ra;
   logic [1:0]  rb;
   logic [1:0]  rc;
   logic [7:0]  va;
   logic [7:0]  vb;
   logic [7:0]  vc;
   logic        wen;
   logic [7:0]  wdata;

   // Extra pointer MSB distinguishes full from empty.
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) &&
                  (wptr[AW-1:0] == rptr[AW-1:0]);
   assign push  = bus.inst_vld & ~full;
   assign pop   = (state == IDLE) & ~empty;

   assign bus.inst_rdy = ~full;
   assign busy         = (state != IDLE) | ~empty;

   assign {op, ra, rb, rc} = cur_inst;
   assign va = rf[ra];
   assign vb = rf[rb];
   assign vc = rf[rc];

   always_ff @(posedge clk) begin
      if (push) begin
         fifo[wptr[AW-1:0]] <= bus.inst_wd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
         drop <= 1'b0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (pop) begin
            rptr <= rptr + 1'b1;
         end
         if (bus.inst_vld & full) begin
            drop <= 1'b1;
         end
      end
   end

   always_comb begin
      wen   = 1'b0;
      wdata = '0;
      unique case (op)
         2'b00: begin
            wen   = 1'b1;
            wdata = {va[3:0], cur_inst[3:0]};
         end
         2'b01: begin
            wen   = 1'b1;
            wdata = vb + vc;
         end
         2'b10: begin
`ifdef SEQ_CTRL_MULT_EN
            wen   = 1'b1;
            wdata = vb * vc;
`endif
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cur_inst    <= '0;
         led         <= '0;
         bus.tx_data <= '0;
         bus.tx_vld  <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            rf[i] <= '0;
         end
      end else begin
         unique case (state)
            IDLE: begin
               if (!empty) begin
                  cur_inst <= fifo[rptr[AW-1:0]];
                  state    <= EXEC;
               end
            end
            EXEC: begin
               if (op == 2'b11) begin
                  bus.tx_data <= va;
                  bus.tx_vld  <= 1'b1;
                  state       <= SEND_WAIT;
               end else begin
                  state <= IDLE;
                  if (wen) begin
                     rf[ra] <= wdata;
                     led    <= wdata;
                  end
               end
            end
            SEND_WAIT: begin
               if (bus.tx_rdy) begin
                  bus.tx_vld <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed vector table, multi-cycle SEND/reset corners and
// randomized traffic against an in-order register-file model.
module tb_seq_ctrl;
   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] led;
   logic       busy;
   logic       drop;

   seq_ctrl_if bus();

   seq_ctrl #(.FIFO_DEPTH(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus.slave),
      .led  (led),
      .busy (busy),
      .drop (drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] w;
      logic [7:0] led;
   } vec_t;

   int         n_pass = 0;
   int         n_tot  = 0;
   int         hs_cnt = 0;
   int         hs0;
   logic [7:0] m_rf [4];
   logic [7:0] m_led;
   logic       m_drop;
   logic [7:0] exp_q [$];
   bit         mon_en = 0;
   bit         prev_hold = 0;
   logic [7:0] prev_data;
   logic [7:0] last_tx;
   vec_t       vec [8];
   logic [7:0] stall_w [5];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
      m_led  = 8'h00;
      m_drop = 1'b0;
      exp_q.delete();
   endtask

   // Architectural effect of one instruction, in issue order.
   task automatic model_apply(input logic [7:0] w);
      int op, ra, rb, rc, res;
      bit wr;
      op = int'(w) / 64;
      ra = (int'(w) / 16) % 4;
      rb = (int'(w) / 4) % 4;
      rc = int'(w) % 4;
      wr = 1;
      res = 0;
      case (op)
         0: res = (int'(m_rf[ra]) % 16) * 16 + int'(w) % 16;
         1: res = (int'(m_rf[rb]) + int'(m_rf[rc])) % 256;
         2: begin
`ifdef SEQ_CTRL_MULT_EN
            res = (int'(m_rf[rb]) * int'(m_rf[rc])) % 256;
`else
            wr = 0;
`endif
         end
         default: begin
            wr = 0;
            exp_q.push_back(m_rf[ra]);
         end
      endcase
      if (wr) begin
         m_rf[ra] = 8'(res);
         m_led    = 8'(res);
      end
   endtask

   task automatic accept(input logic [7:0] w);
      if (bus.inst_rdy) model_apply(w);
      else m_drop = 1'b1;
   endtask

   task automatic drive(input logic [7:0] w);
      bus.inst_vld = 1'b1;
      bus.inst_wd  = w;
      accept(w);
      cyc();
      bus.inst_vld = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || bus.tx_vld) && n < 300) begin
         cyc();
         n++;
      end
      chk("idle_timeout", 32'(busy | bus.tx_vld), 32'(0));
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_led"},      32'(led),          32'h00);
      chk({tag, "_tx_data"},  32'(bus.tx_data),  32'h00);
      chk({tag, "_tx_vld"},   32'(bus.tx_vld),   32'h0);
      chk({tag, "_inst_rdy"}, 32'(bus.inst_rdy), 32'h1);
      chk({tag, "_busy"},     32'(busy),         32'h0);
      chk({tag, "_drop"},     32'(drop),         32'h0);
   endtask

   // Handshake scoreboard and SEND_WAIT stability, sampled at negedge.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         if (prev_hold) begin
            chk("tx_hold", 32'({bus.tx_vld, bus.tx_data}),
                32'({1'b1, prev_data}));
         end
         if (bus.tx_vld && bus.tx_rdy) begin
            hs_cnt++;
            last_tx = bus.tx_data;
            chk("tx_pending", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) begin
               chk("tx_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
            end
         end
         prev_hold = bus.tx_vld & ~bus.tx_rdy;
         prev_data = bus.tx_data;
      end else begin
         prev_hold = 0;
      end
   end

   initial begin
      vec[0] = '{8'h03, 8'h03};
      vec[1] = '{8'h05, 8'h35};
      vec[2] = '{8'h1F, 8'h0F};
      vec[3] = '{8'h27, 8'h07};
      vec[4] = '{8'h76, 8'h16};
`ifdef SEQ_CTRL_MULT_EN
      vec[5] = '{8'h86, 8'h69};
`else
      vec[5] = '{8'h86, 8'h16};
`endif
      vec[6] = '{8'h1F, 8'hFF};
      vec[7] = '{8'h55, 8'hFE};
      stall_w = '{8'h21, 8'h4B, 8'hC0, 8'h39, 8'h11};

      bus.inst_vld = 1'b0;
      bus.inst_wd  = 8'h00;
      bus.tx_rdy   = 1'b0;
      rst = 1'b1;
      model_reset();
      repeat (3) cyc();
      check_reset("por");
      rst = 1'b0;
      mon_en = 1;

      for (int i = 0; i < 8; i++) begin
         drive(vec[i].w);
         cyc();
         cyc();
         chk($sformatf("vec%0d_led", i), 32'(led), 32'(vec[i].led));
      end
      chk("vec_model_led", 32'(led), 32'(m_led));

      bus.tx_rdy = 1'b1;
      drive(8'hC0);
      wait_idle();
`ifdef SEQ_CTRL_MULT_EN
      chk("r0_after_mult", 32'(last_tx), 32'h69);
`else
      chk("r0_after_mult", 32'(last_tx), 32'h35);
`endif

      bus.tx_rdy = 1'b0;
      drive(8'hF0);
      cyc();
      cyc();
      chk("send_vld", 32'(bus.tx_vld), 32'h1);
      chk("send_data", 32'(bus.tx_data), 32'h16);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("stall_rdy%0d", i), 32'(bus.inst_rdy), 32'(i < 4));
         drive(stall_w[i]);
      end
      chk("stall_drop", 32'(drop), 32'h1);
      repeat (13) cyc();
      chk("stall_vld", 32'(bus.tx_vld), 32'h1);
      chk("stall_data", 32'(bus.tx_data), 32'h16);
      hs0 = hs_cnt;
      bus.tx_rdy = 1'b1;
      cyc();
      chk("send_vld_drop", 32'(bus.tx_vld), 32'h0);
      chk("send_hs_once", 32'(hs_cnt - hs0), 32'(1));
      wait_idle();
      chk("queue_hs", 32'(hs_cnt - hs0), 32'(2));
      chk("queue_r0_sent", 32'(last_tx), 32'h87);
      chk("queue_led", 32'(led), 32'h69);
      chk("queue_expq", 32'(exp_q.size()), 32'(0));
      chk("drop_sticky", 32'(drop), 32'h1);

      bus.tx_rdy = 1'b0;
      drive(8'hD0);
      cyc();
      cyc();
      chk("sw_vld", 32'(bus.tx_vld), 32'h1);
      chk("sw_data", 32'(bus.tx_data), 32'hFE);
      drive(8'h24);
      drive(8'h24);
      rst = 1'b1;
      cyc();
      check_reset("mid");
      model_reset();
      rst = 1'b0;
      repeat (6) cyc();
      chk("flush_led", 32'(led), 32'h00);
      chk("flush_busy", 32'(busy), 32'h0);
      chk("flush_vld", 32'(bus.tx_vld), 32'h0);
      bus.tx_rdy = 1'b1;
      hs0 = hs_cnt;
      drive(8'hE0);
      wait_idle();
      chk("flush_r2", 32'(last_tx), 32'h00);
      chk("flush_hs", 32'(hs_cnt - hs0), 32'(1));

      rst = 1'b1;
      cyc();
      model_reset();
      rst = 1'b0;
      for (int c = 0; c < 600; c++) begin
         logic [7:0] w;
         if (c < 300) bus.tx_rdy = ($urandom_range(0, 3) == 0);
         else bus.tx_rdy = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            w = 8'($urandom_range(0, 255));
            bus.inst_vld = 1'b1;
            bus.inst_wd  = w;
            accept(w);
         end else begin
            bus.inst_vld = 1'b0;
         end
         cyc();
      end
      bus.inst_vld = 1'b0;
      bus.tx_rdy   = 1'b1;
      wait_idle();
      chk("rnd_drop", 32'(drop), 32'(m_drop));
      chk("rnd_led", 32'(led), 32'(m_led));
      for (int r = 0; r < 4; r++) begin
         drive({2'b11, 2'(r), 4'h0});
         wait_idle();
      end
      chk("rnd_expq", 32'(exp_q.size()), 32'(0));

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
